drag_tree_sequencer: RTL and testbench
======================================

Name: drag_tree_sequencer

Overview:
- Multi-lane drag-race start-tree controller for the DE2 board.
- A start pulse triggers a timed sequence of amber lights, then green. Each lane's launch is then judged as a foul (early) or a reaction, and the winner is decided.
- All lights and lane results drive 7-segment HEX displays. Segments are active-low: 7'b0000000 is all on, 7'b1111111 is all off.

Parameters:
- LANES, 2, number of racing lanes (1..4).
- AMBER_STAGES, 3, number of amber lights lit one at a time before green (1..4).
- TICKS_PER_STEP, 25_000_000, clock cycles per amber step (0.5 s at 50 MHz); must be ≥2.
- TIMEOUT_STEPS, 8, GREEN duration in steps before the race is abandoned.
- RT_W, 32, width of the reaction-time counter (saturating).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  synchronous start request pulse; acted on only in IDLE or DONE.
- launch  in  LANES  synchronous, debounced launch levels, one bit per lane; the rising edge is the event.
- hex_tree  out  (AMBER_STAGES+1)*7  tree displays; digit k (k < AMBER_STAGES) is amber k, the top digit is green.
- hex_lane  out  LANES*7  per-lane result display.
- busy  out  1  high in AMBER or GREEN.
- foul  out  LANES  latched early-launch flags.
- winner  out  LANES  latched winner flags.
- reaction  out  RT_W  cycles from GREEN entry to the winning launch edge.

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - All hex_tree and hex_lane digits are 7'h7F.
  - busy, foul, winner and reaction are 0.
  - Launch-history registers are 0.
- Launch event: launch_evt[i] = launch[i] & ~launch_q[i], where launch_q is launch registered each cycle.
- States: IDLE, AMBER, GREEN, DONE.
- IDLE / DONE:
  - start=1 sampled at edge t → AMBER with step index 0 and timer cleared, effective at t+1.
  - On the same edge, foul, winner and reaction are cleared and hex_lane is set to off.
  - DONE holds all results until then.
- AMBER:
  - Only digit k of hex_tree is 7'h00; all others are 7'h7F.
  - Each step lasts exactly TICKS_PER_STEP cycles.
  - After the last step: GREEN.
  - start is ignored.
- GREEN:
  - Green digit is on; amber digits are off.
  - reaction counts up from 0 in the first GREEN cycle and saturates at all-ones.
- Foul:
  - launch_evt[i] in AMBER sets foul[i]; the flag is sticky.
  - hex_lane[i] becomes HEX_FOUL (7'b0111111, segment g only) on the next cycle.
  - A fouled lane can never win.
- Win:
  - The first cycle in GREEN with any launch_evt on a non-fouled lane sets winner for every such lane (ties allowed) and latches reaction.
  - The state then moves to DONE.
  - Winner lanes show 7'h00. Non-winning, non-fouled lanes stay 7'h7F.
- GREEN exits to DONE with winner=0 when either:
  - all lanes are fouled (in the first GREEN cycle), or
  - TIMEOUT_STEPS*TICKS_PER_STEP cycles elapse.
- Launch events in DONE or IDLE are ignored, but launch_q still tracks launch.
- Reset mid-race: immediate return to the reset values, with no residual light or flag.
- All outputs are registered. Output latency is one cycle after the deciding edge.

Decomposition:
- Package drag_race_pkg holds:
  - state enum (IDLE, AMBER, GREEN, DONE);
  - HEX_ON = 7'b0000000, HEX_OFF = 7'b1111111, HEX_FOUL = 7'b0111111.
- Sub-module drag_step_timer, parametrised by TICKS_PER_STEP:
  - inputs clr and en; outputs a one-cycle step_done pulse and a step counter;
  - used for both the amber steps and the GREEN timeout.

Test Plan (LANES=2, AMBER_STAGES=3, TICKS_PER_STEP=4, TIMEOUT_STEPS=8):
- Reset held, then released → all 4 tree digits and both lane digits are 7'h7F; busy=0, foul=0, winner=0.
- start pulse at cycle 0 → amber0 on cycles 1-4, amber1 on 5-8, amber2 on 9-12, green from 13, busy=1 throughout.
- Lane1 rises at cycle 10, lane0 rises at cycle 15 → foul=2'b10 and hex_lane1=7'b0111111 at cycle 11; winner=2'b01 and reaction=2 with DONE at 16; hex_lane0=7'h00.
- Both lanes rise at cycle 13 → winner=2'b11, reaction=0.
- No launches → DONE at cycle 45 with winner=0; a later start restarts the sequence and clears the flags.
- rst_n dropped at cycle 7 (amber1 on) → all digits 7'h7F and state IDLE in the same cycle; a start then works normally.

Source files
------------

// File: rtl/drag_race_pkg.sv
// Shared types and display constants for the drag-race start tree.
// Segments are active-low, so a cleared pattern lights every segment.
package drag_race_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        AMBER = 2'd1,
        GREEN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [6:0] HEX_ON   = 7'b0000000;
    localparam logic [6:0] HEX_OFF  = 7'b1111111;
    localparam logic [6:0] HEX_FOUL = 7'b0111111;

endpackage

// File: rtl/drag_step_timer.sv
// Step timer: counts TICKS_PER_STEP enabled cycles per step and keeps a step count.
// step_done is high during the last tick of each step, so the owner can act on that same edge.
module drag_step_timer #(
    parameter int TICKS_PER_STEP = 25_000_000,
    parameter int STEP_W         = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    output logic              step_done,
    output logic [STEP_W-1:0] step
);

    localparam int TICK_W = $clog2(TICKS_PER_STEP);
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICKS_PER_STEP - 1);

    logic [TICK_W-1:0] tick;

    assign step_done = en && (tick == TICK_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick <= '0;
            step <= '0;
        end else if (clr) begin
            tick <= '0;
            step <= '0;
        end else if (en) begin
            if (tick == TICK_MAX) begin
                tick <= '0;
                step <= step + 1'b1;
            end else begin
                tick <= tick + 1'b1;
            end
        end
    end

endmodule

// File: rtl/drag_tree_sequencer.sv
// Drag-race start tree: amber countdown, green, per-lane foul/win judging.
// Every output is registered and reflects the decision made on the previous edge.
module drag_tree_sequencer
    import drag_race_pkg::*;
#(
    parameter int LANES          = 2,
    parameter int AMBER_STAGES   = 3,
    parameter int TICKS_PER_STEP = 25_000_000,
    parameter int TIMEOUT_STEPS  = 8,
    parameter int RT_W           = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [LANES-1:0]              launch,
    output logic [(AMBER_STAGES+1)*7-1:0] hex_tree,
    output logic [LANES*7-1:0]            hex_lane,
    output logic                          busy,
    output logic [LANES-1:0]              foul,
    output logic [LANES-1:0]              winner,
    output logic [RT_W-1:0]               reaction
);

    localparam int TREE_W    = (AMBER_STAGES + 1) * 7;
    localparam int MAX_STEPS = (AMBER_STAGES > TIMEOUT_STEPS) ? AMBER_STAGES : TIMEOUT_STEPS;
    localparam int STEP_W    = $clog2(MAX_STEPS + 1);
    localparam logic [STEP_W-1:0] LAST_AMBER   = STEP_W'(AMBER_STAGES - 1);
    localparam logic [STEP_W-1:0] LAST_TIMEOUT = STEP_W'(TIMEOUT_STEPS - 1);

    state_t            state;
    logic [LANES-1:0]  launch_q;
    logic [LANES-1:0]  launch_evt;
    logic [LANES-1:0]  win_mask;
    logic [RT_W-1:0]   rt_cnt;
    logic              step_done;
    logic [STEP_W-1:0] step;
    logic              timer_en;
    logic              timer_clr;
    logic              amber_last;
    logic              green_timeout;

    function automatic logic [TREE_W-1:0] tree_digit(input int idx);
        logic [TREE_W-1:0] t;
        t = {TREE_W{1'b1}};
        t[idx*7 +: 7] = HEX_ON;
        return t;
    endfunction

    assign launch_evt    = launch & ~launch_q;
    assign win_mask      = launch_evt & ~foul;
    assign amber_last    = step_done && (step == LAST_AMBER);
    assign green_timeout = step_done && (step == LAST_TIMEOUT);
    assign timer_en      = (state == AMBER) || (state == GREEN);
    // The timer restarts both at race start and at green entry so it can time the timeout too.
    assign timer_clr     = (((state == IDLE) || (state == DONE)) && start)
                         || ((state == AMBER) && amber_last);

    drag_step_timer #(
        .TICKS_PER_STEP(TICKS_PER_STEP),
        .STEP_W        (STEP_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (timer_clr),
        .en       (timer_en),
        .step_done(step_done),
        .step     (step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            launch_q <= '0;
            rt_cnt   <= '0;
            hex_tree <= {TREE_W{1'b1}};
            hex_lane <= {(LANES*7){1'b1}};
            busy     <= 1'b0;
            foul     <= '0;
            winner   <= '0;
            reaction <= '0;
        end else begin
            launch_q <= launch;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= AMBER;
                        busy     <= 1'b1;
                        foul     <= '0;
                        winner   <= '0;
                        reaction <= '0;
                        hex_lane <= {(LANES*7){1'b1}};
                        hex_tree <= tree_digit(0);
                    end
                end
                AMBER: begin
                    for (int i = 0; i < LANES; i++) begin
                        if (launch_evt[i]) begin
                            foul[i]            <= 1'b1;
                            hex_lane[i*7 +: 7] <= HEX_FOUL;
                        end
                    end
                    if (step_done) begin
                        if (amber_last) begin
                            state    <= GREEN;
                            rt_cnt   <= '0;
                            hex_tree <= tree_digit(AMBER_STAGES);
                        end else begin
                            hex_tree <= tree_digit(int'(step) + 1);
                        end
                    end
                end
                GREEN: begin
                    if (rt_cnt != {RT_W{1'b1}}) begin
                        rt_cnt <= rt_cnt + 1'b1;
                    end
                    // A real launch beats a timeout landing on the same cycle.
                    if (|win_mask) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        winner   <= win_mask;
                        reaction <= rt_cnt;
                        hex_tree <= {TREE_W{1'b1}};
                        for (int i = 0; i < LANES; i++) begin
                            if (win_mask[i]) begin
                                hex_lane[i*7 +: 7] <= HEX_ON;
                            end
                        end
                    end else if ((&foul) || green_timeout) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        hex_tree <= {TREE_W{1'b1}};
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drag_tree_sequencer.sv
// Bench for drag_tree_sequencer: a constant vector table for one race, hand-written
// corner sequences, then random launches checked against a timeline model of the race.
module tb_drag_tree_sequencer;
    import drag_race_pkg::*;

    localparam int LANES   = 2;
    localparam int AMBERS  = 3;
    localparam int TICKS   = 4;
    localparam int TIMEOUT = 8;
    localparam int RT_W    = 32;
    localparam int TREE_W  = (AMBERS + 1) * 7;
    localparam int LANE_W  = LANES * 7;

    localparam logic [LANE_W-1:0] L_OFF    = {HEX_OFF, HEX_OFF};
    localparam logic [LANE_W-1:0] L_F1     = {HEX_FOUL, HEX_OFF};
    localparam logic [LANE_W-1:0] L_F1_W0  = {HEX_FOUL, HEX_ON};
    localparam logic [LANE_W-1:0] L_W_BOTH = {HEX_ON, HEX_ON};
    localparam logic [LANE_W-1:0] L_F_BOTH = {HEX_FOUL, HEX_FOUL};

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [LANES-1:0]  launch = '0;
    logic [TREE_W-1:0] hex_tree;
    logic [LANE_W-1:0] hex_lane;
    logic              busy;
    logic [LANES-1:0]  foul;
    logic [LANES-1:0]  winner;
    logic [RT_W-1:0]   reaction;

    int errors = 0;
    int checks = 0;

    // Timeline model: m_k is the cycle number since the start edge, counted from 1.
    bit         m_running;
    int         m_k;
    logic [1:0] m_prev;
    logic [1:0] m_foul;
    logic [1:0] m_winner;
    int         m_reaction;

    typedef struct {
        logic              start;
        logic [1:0]        launch;
        int                tree_sel;
        logic              busy;
        logic [1:0]        foul;
        logic [1:0]        winner;
        int                reaction;
        logic [LANE_W-1:0] lane;
    } vec_t;

    vec_t vecs[17];

    always #5 clk = ~clk;

    drag_tree_sequencer #(
        .LANES         (LANES),
        .AMBER_STAGES  (AMBERS),
        .TICKS_PER_STEP(TICKS),
        .TIMEOUT_STEPS (TIMEOUT),
        .RT_W          (RT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .launch  (launch),
        .hex_tree(hex_tree),
        .hex_lane(hex_lane),
        .busy    (busy),
        .foul    (foul),
        .winner  (winner),
        .reaction(reaction)
    );

    function automatic logic [TREE_W-1:0] tree_of(input int sel);
        logic [TREE_W-1:0] t;
        t = {TREE_W{1'b1}};
        if (sel >= 0) t[sel*7 +: 7] = HEX_ON;
        return t;
    endfunction

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_output(input string tag, input logic [TREE_W-1:0] e_tree,
                                input logic [LANE_W-1:0] e_lane, input logic e_busy,
                                input logic [1:0] e_foul, input logic [1:0] e_winner,
                                input int e_reaction);
        check_val({tag, " hex_tree"}, 64'(hex_tree), 64'(e_tree));
        check_val({tag, " hex_lane"}, 64'(hex_lane), 64'(e_lane));
        check_val({tag, " busy"},     64'(busy),     64'(e_busy));
        check_val({tag, " foul"},     64'(foul),     64'(e_foul));
        check_val({tag, " winner"},   64'(winner),   64'(e_winner));
        check_val({tag, " reaction"}, 64'(reaction), 64'(32'(e_reaction)));
    endtask

    task automatic model_reset();
        m_running  = 1'b0;
        m_k        = 0;
        m_prev     = '0;
        m_foul     = '0;
        m_winner   = '0;
        m_reaction = 0;
    endtask

    task automatic model_edge(input logic s, input logic [1:0] l);
        logic [1:0] evt;
        logic [1:0] w;
        int g;
        evt    = l & ~m_prev;
        m_prev = l;
        if (!m_running) begin
            if (s) begin
                m_running  = 1'b1;
                m_k        = 1;
                m_foul     = '0;
                m_winner   = '0;
                m_reaction = 0;
            end
        end else if (m_k <= AMBERS * TICKS) begin
            m_foul = m_foul | evt;
            m_k++;
        end else begin
            g = m_k - AMBERS * TICKS - 1;
            w = evt & ~m_foul;
            if (w != 0) begin
                m_winner   = w;
                m_reaction = g;
                m_running  = 1'b0;
            end else if (m_foul == 2'b11 || g + 1 == TIMEOUT * TICKS) begin
                m_running = 1'b0;
            end else begin
                m_k++;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [TREE_W-1:0] e_tree;
        logic [LANE_W-1:0] e_lane;
        if (!m_running)                 e_tree = tree_of(-1);
        else if (m_k <= AMBERS * TICKS) e_tree = tree_of((m_k - 1) / TICKS);
        else                            e_tree = tree_of(AMBERS);
        for (int i = 0; i < LANES; i++) begin
            if (m_winner[i])    e_lane[i*7 +: 7] = HEX_ON;
            else if (m_foul[i]) e_lane[i*7 +: 7] = HEX_FOUL;
            else                e_lane[i*7 +: 7] = HEX_OFF;
        end
        check_output(tag, e_tree, e_lane, m_running, m_foul, m_winner, m_reaction);
    endtask

    // Drive inputs for one cycle; on return the outputs show the result of that edge.
    task automatic apply_stimulus(input logic s, input logic [1:0] l);
        start  = s;
        launch = l;
        model_edge(s, l);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] rl;
        model_reset();

        vecs[0] = '{1'b1, 2'b00, 0, 1'b1, 2'b00, 2'b00, 0, L_OFF};
        for (int k = 1; k <= 9; k++) vecs[k] = '{1'b0, 2'b00, k / TICKS, 1'b1, 2'b00, 2'b00, 0, L_OFF};
        vecs[10] = '{1'b0, 2'b10,  2, 1'b1, 2'b10, 2'b00, 0, L_F1};
        vecs[11] = '{1'b0, 2'b10,  2, 1'b1, 2'b10, 2'b00, 0, L_F1};
        vecs[12] = '{1'b0, 2'b10,  3, 1'b1, 2'b10, 2'b00, 0, L_F1};
        vecs[13] = '{1'b0, 2'b10,  3, 1'b1, 2'b10, 2'b00, 0, L_F1};
        vecs[14] = '{1'b0, 2'b10,  3, 1'b1, 2'b10, 2'b00, 0, L_F1};
        vecs[15] = '{1'b0, 2'b11, -1, 1'b0, 2'b10, 2'b01, 2, L_F1_W0};
        vecs[16] = '{1'b0, 2'b11, -1, 1'b0, 2'b10, 2'b01, 2, L_F1_W0};

        repeat (3) @(posedge clk);
        #1;
        check_output("reset held", tree_of(-1), L_OFF, 1'b0, 2'b00, 2'b00, 0);
        rst_n = 1'b1;
        apply_stimulus(1'b0, 2'b00);
        check_output("after reset", tree_of(-1), L_OFF, 1'b0, 2'b00, 2'b00, 0);

        for (int n = 0; n < 17; n++) begin
            apply_stimulus(vecs[n].start, vecs[n].launch);
            check_output($sformatf("vec cycle %0d", n + 1), tree_of(vecs[n].tree_sel), vecs[n].lane,
                         vecs[n].busy, vecs[n].foul, vecs[n].winner, vecs[n].reaction);
        end

        // Timeout race, also checks that a restart from DONE clears the earlier foul/win.
        apply_stimulus(1'b1, 2'b00);
        check_output("restart clears", tree_of(0), L_OFF, 1'b1, 2'b00, 2'b00, 0);
        for (int n = 1; n < 44; n++) apply_stimulus(1'b0, 2'b00);
        check_output("timeout cycle 44", tree_of(AMBERS), L_OFF, 1'b1, 2'b00, 2'b00, 0);
        apply_stimulus(1'b0, 2'b00);
        check_output("timeout cycle 45", tree_of(-1), L_OFF, 1'b0, 2'b00, 2'b00, 0);

        // Both lanes launch on the first green cycle.
        apply_stimulus(1'b1, 2'b00);
        for (int n = 1; n < 13; n++) apply_stimulus(1'b0, 2'b00);
        check_output("tie cycle 13", tree_of(AMBERS), L_OFF, 1'b1, 2'b00, 2'b00, 0);
        apply_stimulus(1'b0, 2'b11);
        check_output("tie cycle 14", tree_of(-1), L_W_BOTH, 1'b0, 2'b00, 2'b11, 0);

        // Every lane fouls, so green ends after its first cycle with no winner.
        apply_stimulus(1'b1, 2'b00);
        for (int n = 1; n < 5; n++) apply_stimulus(1'b0, 2'b00);
        apply_stimulus(1'b0, 2'b11);
        check_output("all foul cycle 6", tree_of(1), L_F_BOTH, 1'b1, 2'b11, 2'b00, 0);
        for (int n = 6; n < 13; n++) apply_stimulus(1'b0, 2'b11);
        check_output("all foul cycle 13", tree_of(AMBERS), L_F_BOTH, 1'b1, 2'b11, 2'b00, 0);
        apply_stimulus(1'b0, 2'b11);
        check_output("all foul cycle 14", tree_of(-1), L_F_BOTH, 1'b0, 2'b11, 2'b00, 0);

        // Asynchronous reset in the middle of amber1.
        apply_stimulus(1'b1, 2'b00);
        for (int n = 1; n < 7; n++) apply_stimulus(1'b0, 2'b00);
        check_output("pre-reset cycle 7", tree_of(1), L_OFF, 1'b1, 2'b00, 2'b00, 0);
        #2 rst_n = 1'b0;
        #1;
        check_output("mid-race reset", tree_of(-1), L_OFF, 1'b0, 2'b00, 2'b00, 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        apply_stimulus(1'b1, 2'b00);
        check_output("start after reset", tree_of(0), L_OFF, 1'b1, 2'b00, 2'b00, 0);

        // Random launches and starts against the model.
        rl = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < LANES; i++) begin
                if ($urandom_range(0, 11) == 0) rl[i] = ~rl[i];
            end
            apply_stimulus($urandom_range(0, 19) == 0, rl);
            check_model($sformatf("random cycle %0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
